shot_magazine_fsm: RTL and testbench
====================================

// Module: shot_magazine_fsm
// PURPOSE
//  Parametrised trigger/ammo controller for the light-gun front end. Synchronises and
//  debounces the raw trigger, counts shots per round up to MAX_SHOTS, and emits one-cycle
//  shot/dry-fire pulses to the hit-detection and audio logic. Supports mid-round reload.
//  Sits between the gun input pin and the round/score controller.
// PARAMETERS
//  MAX_SHOTS        3   shots per magazine; legal range 1..15
//  DEBOUNCE_CYCLES  4   extra stable cycles required before a trigger level change is accepted
//  CNT_W            $clog2(MAX_SHOTS+1)   derived width of shots_left
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      asynchronous, active-low reset
//  gun_shot    in   1      raw trigger, active-high, asynchronous to clk
//  reload      in   1      synchronous level from round controller; refills magazine
//  state       out  2      current FSM state (encoding from gun_pkg)
//  shots_left  out  CNT_W  rounds remaining in magazine
//  shot_pulse  out  1      one-cycle pulse per accepted shot
//  dry_pulse   out  1      one-cycle pulse per trigger press while empty
//  empty       out  1      high when shots_left == 0
// BEHAVIOUR
//  Reset (async, any time): state=S_PRELOAD, shots_left=MAX_SHOTS, shot_pulse=0,
//   dry_pulse=0, empty=0, sync flops=0, trig_db=0 (released), debounce count=0.
//  Input path: 2-flop synchroniser (sync1, sync2) then debounce register trig_db.
//   trig_db flips on the edge where sync2 has differed from trig_db for
//   DEBOUNCE_CYCLES+1 consecutive edges (incl. that edge); any agreement clears the count.
//   DEBOUNCE_CYCLES=0 -> trig_db follows sync2 with one register of delay.
//  Latency: first edge sampling gun_shot=1 is edge N; trig_db rises at N+2+DEBOUNCE_CYCLES;
//   shot_pulse high for exactly the cycle after edge N+3+DEBOUNCE_CYCLES.
//  States:
//   S_PRELOAD: wait for trig_db=0 -> S_ARMED (a trigger held through reset/reload never fires)
//   S_ARMED:   trig_db rising -> shot_pulse=1, shots_left-=1; if new value 0 -> S_EMPTY
//              else -> S_FIRED
//   S_FIRED:   trig_db=0 -> S_ARMED; stays while held (no auto-fire)
//   S_EMPTY:   empty=1; each trig_db rising edge -> dry_pulse=1; remains until reload/reset
//  Reload: reload=1 in any state -> next cycle shots_left=MAX_SHOTS, state=S_PRELOAD,
//   empty=0, no pulses that cycle. Reload has priority over a simultaneous shot/dry edge.
//   Reload held multiple cycles: remains in S_PRELOAD, no shots accepted.
//  shots_left never underflows or exceeds MAX_SHOTS; decrement only on an accepted shot.
//  shot_pulse and dry_pulse are registered, mutually exclusive, never high two cycles running.
//  Rising edge of trig_db detected against its own previous value (trig_db_q).
// STRUCTURE
//  gun_pkg: state localparams S_PRELOAD=2'b00, S_ARMED=2'b01, S_FIRED=2'b10, S_EMPTY=2'b11;
//   default MAX_SHOTS, DEBOUNCE_CYCLES constants shared with round controller.
//  Sub-module trigger_debounce: synchroniser + debounce counter, output trig_db and
//   trig_rise (one-cycle). FSM, ammo counter and pulse registers live in this module.
// TESTING
//  1 Reset with gun_shot=1 held, D=4 -> state stays S_PRELOAD, no shot_pulse; release then
//    press -> exactly one shot_pulse, shots_left 3->2.
//  2 MAX_SHOTS=3: three clean 20-cycle presses -> 3 shot_pulses, shots_left 2,1,0, empty=1
//    after 3rd; 4th press -> dry_pulse=1 once, no shot_pulse, shots_left stays 0.
//  3 D=4: 4-cycle gun_shot glitch -> no pulse; 5-cycle press -> shot_pulse at edge N+7.
//  4 reload pulsed in S_FIRED with trigger held -> shots_left=3, state S_PRELOAD, no shot until
//    release and new press.
//  5 reload asserted on same cycle trig_db rises in S_ARMED -> no shot_pulse, shots_left=3.
//  6 reset_n asserted mid-debounce in S_FIRED, shots_left=1 -> all outputs at reset values
//    immediately (asynchronously), before the next clk edge.

Source files
------------

// File: rtl/gun_pkg.sv
// rtl/gun_pkg.sv - shared state encoding and defaults for the light-gun front end
package gun_pkg;

  localparam logic [1:0] S_PRELOAD = 2'b00;
  localparam logic [1:0] S_ARMED   = 2'b01;
  localparam logic [1:0] S_FIRED   = 2'b10;
  localparam logic [1:0] S_EMPTY   = 2'b11;

  localparam int GUN_MAX_SHOTS       = 3;
  localparam int GUN_DEBOUNCE_CYCLES = 4;

  typedef logic [1:0] gun_state_t;

  // Width of a counter that must hold values 0..n, never narrower than one bit.
  function automatic int width_for(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/trigger_debounce.sv
// rtl/trigger_debounce.sv - trigger synchroniser, debounce filter and edge detect
module trigger_debounce
  import gun_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = GUN_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_trig_db,
  output logic o_trig_rise,
  output logic o_released
);

  localparam int DB_W         = width_for(DEBOUNCE_CYCLES);
  // Released must cover the synchroniser depth too, so a trigger held through
  // reset (flops cleared to 0) is not mistaken for a released one.
  localparam int QUIET_CYCLES = DEBOUNCE_CYCLES + 3;
  localparam int Q_W          = width_for(QUIET_CYCLES);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_trig_db;
  logic            r_trig_db_q;
  logic [DB_W-1:0] r_db_cnt;
  logic [Q_W-1:0]  r_quiet_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_trig_db   <= 1'b0;
      r_trig_db_q <= 1'b0;
      r_db_cnt    <= '0;
      r_quiet_cnt <= '0;
    end else begin
      r_sync1     <= i_raw;
      r_sync2     <= r_sync1;
      r_trig_db_q <= r_trig_db;

      if (r_sync2 != r_trig_db) begin
        if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES)) begin
          r_trig_db <= r_sync2;
          r_db_cnt  <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end

      if (r_sync2) begin
        r_quiet_cnt <= '0;
      end else if (r_quiet_cnt != Q_W'(QUIET_CYCLES)) begin
        r_quiet_cnt <= r_quiet_cnt + Q_W'(1);
      end
    end
  end

  assign o_trig_db   = r_trig_db;
  assign o_trig_rise = r_trig_db & ~r_trig_db_q;
  assign o_released  = ~r_trig_db & (r_quiet_cnt == Q_W'(QUIET_CYCLES));

endmodule

// File: rtl/shot_magazine_fsm.sv
// rtl/shot_magazine_fsm.sv - trigger/ammo controller emitting shot and dry-fire pulses
module shot_magazine_fsm
  import gun_pkg::*;
#(
  parameter int  MAX_SHOTS       = GUN_MAX_SHOTS,
  parameter int  DEBOUNCE_CYCLES = GUN_DEBOUNCE_CYCLES,
  localparam int CNT_W           = $clog2(MAX_SHOTS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             gun_shot,
  input  logic             reload,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] shots_left,
  output logic             shot_pulse,
  output logic             dry_pulse,
  output logic             empty
);

  logic             w_trig_db;
  logic             w_trig_rise;
  logic             w_released;

  gun_state_t       r_state;
  logic [CNT_W-1:0] r_shots_left;
  logic             r_shot_pulse;
  logic             r_dry_pulse;

  trigger_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_trigger_debounce (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_raw      (gun_shot),
    .o_trig_db  (w_trig_db),
    .o_trig_rise(w_trig_rise),
    .o_released (w_released)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_PRELOAD;
      r_shots_left <= CNT_W'(MAX_SHOTS);
      r_shot_pulse <= 1'b0;
      r_dry_pulse  <= 1'b0;
    end else begin
      r_shot_pulse <= 1'b0;
      r_dry_pulse  <= 1'b0;
      // Reload wins over any trigger edge in the same cycle.
      if (reload) begin
        r_state      <= S_PRELOAD;
        r_shots_left <= CNT_W'(MAX_SHOTS);
      end else begin
        case (r_state)
          S_PRELOAD: begin
            if (w_released) begin
              r_state <= S_ARMED;
            end
          end
          S_ARMED: begin
            if (w_trig_rise && (r_shots_left != '0)) begin
              r_shot_pulse <= 1'b1;
              r_shots_left <= r_shots_left - CNT_W'(1);
              r_state      <= (r_shots_left == CNT_W'(1)) ? S_EMPTY : S_FIRED;
            end
          end
          S_FIRED: begin
            if (!w_trig_db) begin
              r_state <= S_ARMED;
            end
          end
          S_EMPTY: begin
            if (w_trig_rise) begin
              r_dry_pulse <= 1'b1;
            end
          end
          default: r_state <= S_PRELOAD;
        endcase
      end
    end
  end

  assign state      = r_state;
  assign shots_left = r_shots_left;
  assign shot_pulse = r_shot_pulse;
  assign dry_pulse  = r_dry_pulse;
  assign empty      = (r_shots_left == '0);

endmodule

// File: tb/tb_shot_magazine_fsm.sv
// tb/tb_shot_magazine_fsm.sv - scoreboard bench for shot_magazine_fsm
module tb_shot_magazine_fsm;

  localparam int MAXS = 3;
  localparam int D    = 4;

  typedef struct {
    bit dry;
    int cyc;
    int left;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       gun_shot;
  logic       reload;
  logic [1:0] state;
  logic [1:0] shots_left;
  logic       shot_pulse;
  logic       dry_pulse;
  logic       empty;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ammo = MAXS;
  exp_t q[$];
  exp_t e_mon;

  shot_magazine_fsm #(.MAX_SHOTS(MAXS), .DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .gun_shot  (gun_shot),
    .reload    (reload),
    .state     (state),
    .shots_left(shots_left),
    .shot_pulse(shot_pulse),
    .dry_pulse (dry_pulse),
    .empty     (empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: a press longer than D cycles is one trigger pull; it fires if
  // ammo remains, otherwise dry-fires, D+3 edges after it is first sampled.
  task automatic press(input int len, input int gap);
    exp_t e;
    if (len > D) begin
      e.dry = (ammo == 0);
      if (ammo > 0) ammo--;
      e.left = ammo;
      e.cyc  = cyc + 1 + 3 + D;
      q.push_back(e);
    end
    gun_shot = 1'b1;
    cycles(len);
    gun_shot = 1'b0;
    cycles(gap);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    cycles(1);
    reload = 1'b0;
    ammo = MAXS;
    cycles(3);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
        e_mon = q.pop_front();
        chk("missed_pulse_cycle", cyc, e_mon.cyc);
      end
      if (shot_pulse || dry_pulse) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pulse: got shot=%0d dry=%0d expected none (cycle %0d)",
                   shot_pulse, dry_pulse, cyc);
        end else begin
          e_mon = q.pop_front();
          chk("pulse_kind_dry", int'(dry_pulse), int'(e_mon.dry));
          chk("pulse_cycle", cyc, e_mon.cyc);
          chk("pulse_shots_left", int'(shots_left), e_mon.left);
          chk("pulse_exclusive", int'(shot_pulse & dry_pulse), 0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    gun_shot = 1'b1;
    reload   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'(state), 0);
    chk("reset_shots_left", int'(shots_left), MAXS);
    chk("reset_pulses", int'(shot_pulse | dry_pulse), 0);
    chk("reset_empty", int'(empty), 0);

    // Trigger held through reset must not fire.
    reset_n = 1'b1;
    cycles(40);
    chk("held_through_reset_preload", int'(state), 0);
    chk("held_through_reset_shots", int'(shots_left), MAXS);
    gun_shot = 1'b0;
    cycles(D + 12);
    chk("armed_after_release", int'(state), 1);

    // Empty the magazine, then dry-fire.
    press(20, D + 10);
    chk("first_shot_left", int'(shots_left), 2);
    press(20, D + 10);
    press(20, D + 10);
    chk("empty_shots_left", int'(shots_left), 0);
    chk("empty_flag", int'(empty), 1);
    chk("empty_state", int'(state), 3);
    press(20, D + 10);
    chk("dry_shots_left", int'(shots_left), 0);
    chk("dry_state", int'(state), 3);

    // Glitch of exactly D cycles is rejected, D+1 is accepted.
    do_reload();
    chk("reload_shots_left", int'(shots_left), MAXS);
    chk("reload_empty", int'(empty), 0);
    press(D, D + 10);
    chk("glitch_no_shot", int'(shots_left), MAXS);
    press(D + 1, D + 10);
    chk("min_press_shot", int'(shots_left), 2);

    // Reload while held in FIRED.
    press_hold_reload();

    // Reload coincident with the debounced rising edge.
    ammo_check_reload_race();

    // Async reset mid-debounce in FIRED with one shot left.
    press(20, D + 10);
    gun_shot = 1'b1;
    begin
      exp_t e;
      ammo--;
      e.dry = 1'b0;
      e.left = ammo;
      e.cyc = cyc + 1 + 3 + D;
      q.push_back(e);
    end
    cycles(D + 8);
    chk("pre_reset_state", int'(state), 2);
    chk("pre_reset_shots", int'(shots_left), 1);
    gun_shot = 1'b0;
    cycles(2);
    chk("mid_debounce_state", int'(state), 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_state", int'(state), 0);
    chk("async_reset_shots", int'(shots_left), MAXS);
    chk("async_reset_pulses", int'(shot_pulse | dry_pulse), 0);
    chk("async_reset_empty", int'(empty), 0);
    ammo = MAXS;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycles(D + 12);

    // Randomised presses, glitches and reloads against the reference.
    for (int i = 0; i < 40; i++) begin
      int a;
      int g;
      a = $urandom_range(0, 9);
      g = $urandom_range(D + 8, D + 20);
      if (a < 2) begin
        do_reload();
        cycles(g);
      end else if (a < 4) begin
        press($urandom_range(1, D), g);
      end else begin
        press($urandom_range(D + 1, D + 15), g);
      end
      chk("rand_shots_left", int'(shots_left), ammo);
      chk("rand_empty", int'(empty), int'(ammo == 0));
    end

    for (int k = 0; k < 100 && q.size() != 0; k++) cycles(1);
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  task automatic press_hold_reload();
    exp_t e;
    e.dry = 1'b0;
    ammo--;
    e.left = ammo;
    e.cyc = cyc + 1 + 3 + D;
    q.push_back(e);
    gun_shot = 1'b1;
    cycles(D + 6);
    chk("fired_while_held", int'(state), 2);
    reload = 1'b1;
    cycles(1);
    reload = 1'b0;
    ammo = MAXS;
    chk("reload_fired_shots", int'(shots_left), MAXS);
    chk("reload_fired_state", int'(state), 0);
    cycles(20);
    chk("reload_held_preload", int'(state), 0);
    gun_shot = 1'b0;
    cycles(D + 12);
    chk("rearmed_after_release", int'(state), 1);
    press(20, D + 10);
    chk("shot_after_rearm", int'(shots_left), 2);
  endtask

  task automatic ammo_check_reload_race();
    gun_shot = 1'b1;
    cycles(D + 3);
    reload = 1'b1;
    cycles(1);
    reload = 1'b0;
    ammo = MAXS;
    chk("race_shots_left", int'(shots_left), MAXS);
    chk("race_state", int'(state), 0);
    cycles(10);
    gun_shot = 1'b0;
    cycles(D + 12);
    chk("race_no_shot", int'(shots_left), MAXS);
  endtask

endmodule
